collision_score: RTL and testbench

COLLISION_SCORE -- requirements
Module: collision_score

---
 rtl/collision_score.sv | 148 ++++++++++++++
 tb/tb_collision_score.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/collision_score.sv
// Bird/pipe collision detection, game-state FSM and pass scoring for a flappy-style game.
// Define COLLISION_SCORE_HIGH_SCORE_EN to keep a high-score register across games.
module collision_score #(
  parameter int BIRD_W     = 20,
  parameter int BIRD_H     = 20,
  parameter int PIPE_W     = 60,
  parameter int GAP_H      = 150,
  parameter int SCREEN_H   = 480,
  parameter int HIT_FRAMES = 30,
  parameter int SCORE_MAX  = 999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [10:0] bird_x,
  input  logic [9:0]  bird_y,
  input  logic [10:0] pipe_x,
  input  logic [9:0]  pipe_y,
  output logic        pipe_init,
  output logic [1:0]  state,
  output logic        collision,
  output logic [9:0]  score,
  output logic [9:0]  high_score
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_HIT  = 2'd2,
    S_OVER = 2'd3
  } state_t;

  localparam int HCNT_W = $clog2(HIT_FRAMES + 1);

  state_t              r_state;
  state_t              w_next;
  logic                r_collision;
  logic [9:0]          r_score;
  logic [HCNT_W-1:0]   r_hit_cnt;
  logic                r_armed;
  logic                r_first_play;
  logic                r_start_seen;
  logic [10:0]         r_prev_px;

  // Geometry is widened by one bit so edge sums never wrap.
  logic [11:0] w_bird_r;
  logic [11:0] w_pipe_r;
  logic [10:0] w_bird_b;
  logic [10:0] w_gap_top;
  logic        w_ovl_x;
  logic        w_ovl_y;
  logic        w_floor;
  logic        w_hit;
  logic        w_passed;
  logic        w_wrap;
  logic        w_fire;

  assign w_bird_r  = {1'b0, bird_x} + 12'(BIRD_W);
  assign w_pipe_r  = {1'b0, pipe_x} + 12'(PIPE_W);
  assign w_bird_b  = {1'b0, bird_y} + 11'(BIRD_H);
  assign w_gap_top = {1'b0, pipe_y} - 11'(GAP_H);

  assign w_ovl_x = (w_bird_r > {1'b0, pipe_x}) && ({1'b0, bird_x} < w_pipe_r);
  assign w_ovl_y = (({1'b0, pipe_y} >= 11'(GAP_H)) && ({1'b0, bird_y} < w_gap_top)) ||
                   (w_bird_b > {1'b0, pipe_y});
  assign w_floor = (w_bird_b >= 11'(SCREEN_H));
  assign w_hit   = (w_ovl_x && w_ovl_y) || w_floor;

  assign w_passed = (w_pipe_r < {1'b0, bird_x});
  assign w_wrap   = (pipe_x > r_prev_px);
  assign w_fire   = r_armed && w_passed && !w_hit;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_PLAY;
      S_PLAY: if (frame_tick && w_hit) w_next = S_HIT;
      S_HIT:  if (frame_tick && (r_hit_cnt == HCNT_W'(HIT_FRAMES - 1))) w_next = S_OVER;
      S_OVER: if (frame_tick && !start && r_start_seen) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_collision  <= 1'b0;
      r_score      <= '0;
      r_hit_cnt    <= '0;
      r_armed      <= 1'b1;
      r_first_play <= 1'b0;
      r_start_seen <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_first_play <= (r_state == S_IDLE) && (w_next == S_PLAY);
      case (r_state)
        S_IDLE: if (start) begin
          r_score     <= '0;
          r_armed     <= 1'b1;
          r_collision <= 1'b0;
          r_hit_cnt   <= '0;
        end
        S_PLAY: if (frame_tick) begin
          r_collision <= w_hit;
          if (w_fire && (r_score < 10'(SCORE_MAX))) r_score <= r_score + 10'd1;
          // A pipe that jumped right has wrapped and deserves a fresh pass.
          r_armed <= (r_armed && !w_fire) || !w_passed || w_wrap;
        end
        S_HIT: if (frame_tick) begin
          r_hit_cnt <= (w_next == S_OVER) ? '0 : r_hit_cnt + 1'b1;
        end
        S_OVER: begin
          if (start) r_start_seen <= 1'b1;
          if (w_next == S_IDLE) begin
            r_collision  <= 1'b0;
            r_start_seen <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (frame_tick) r_prev_px <= pipe_x;
  end

`ifdef COLLISION_SCORE_HIGH_SCORE_EN
  logic [9:0] r_high;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_high <= '0;
    end else if ((r_state == S_HIT) && (w_next == S_OVER) && (r_score > r_high)) begin
      r_high <= r_score;
    end
  end
  assign high_score = r_high;
`else
  assign high_score = '0;
`endif

  assign pipe_init = (r_state == S_IDLE) || (r_state == S_OVER) || r_first_play;
  assign state     = r_state;
  assign collision = r_collision;
  assign score     = r_score;

endmodule

// File: tb/tb_collision_score.sv
// Directed scoreboard bench for collision_score: FSM flow, geometry, scoring, saturation, async reset.
module tb_collision_score;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic [10:0] bird_x = '0;
  logic [9:0]  bird_y = '0;
  logic [10:0] pipe_x = '0;
  logic [9:0]  pipe_y = '0;
  logic        pipe_init;
  logic [1:0]  state;
  logic        collision;
  logic [9:0]  score;
  logic [9:0]  high_score;

  int n_chk = 0;
  int n_err = 0;
  int exp_hs;

  typedef struct {
    string tag;
    int    st;
    int    coll;
    int    sc;
    int    pi;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  collision_score dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .start      (start),
    .bird_x     (bird_x),
    .bird_y     (bird_y),
    .pipe_x     (pipe_x),
    .pipe_y     (pipe_y),
    .pipe_init  (pipe_init),
    .state      (state),
    .collision  (collision),
    .score      (score),
    .high_score (high_score)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge with the given tick/start; an expectation of -1 skips that field.
  task automatic cyc(input string tag, input bit tk, input bit st,
                     input int est, input int ecoll, input int esc, input int epi);
    exp_t e;
    @(negedge clk);
    frame_tick = tk;
    start      = st;
    e.tag = tag; e.st = est; e.coll = ecoll; e.sc = esc; e.pi = epi;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.st   >= 0) check_val({e.tag, ".state"},     int'(state),     e.st);
    if (e.coll >= 0) check_val({e.tag, ".collision"}, int'(collision), e.coll);
    if (e.sc   >= 0) check_val({e.tag, ".score"},     int'(score),     e.sc);
    if (e.pi   >= 0) check_val({e.tag, ".pipe_init"}, int'(pipe_init), e.pi);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, ".state"},      int'(state),      0);
    check_val({tag, ".collision"},  int'(collision),  0);
    check_val({tag, ".score"},      int'(score),      0);
    check_val({tag, ".pipe_init"},  int'(pipe_init),  1);
    check_val({tag, ".high_score"}, int'(high_score), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef COLLISION_SCORE_HIGH_SCORE_EN
    exp_hs = 999;
`else
    exp_hs = 0;
`endif
    // Power-on reset
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;

    // Start and first pipe geometry checks
    bird_x = 11'd100; bird_y = 10'd200; pipe_x = 11'd90; pipe_y = 10'd300;
    cyc("start",    0, 1, 1, 0, 0, 1);
    cyc("play_pi",  0, 0, 1, 0, 0, 0);
    cyc("no_coll",  1, 0, 1, 0, 0, 0);

    // First pass: exactly one increment, at pipe_x=36
    for (int p = 200; p >= 32; p -= 4) begin
      pipe_x = 11'(p);
      cyc("sweep1", 1, 0, 1, 0, (p <= 36) ? 1 : 0, 0);
    end
    pipe_x = 11'd500;
    cyc("wrap", 1, 0, 1, 0, 1, 0);
    for (int p = 496; p >= 32; p -= 4) begin
      pipe_x = 11'(p);
      cyc("sweep2", 1, 0, 1, 0, (p <= 36) ? 2 : 1, 0);
    end

    // Pipe collision, then async reset mid-HIT
    pipe_x = 11'd90; pipe_y = 10'd210;
    cyc("pipe_hit", 1, 0, 2, 1, 2, 0);
    cyc("hit_idle", 0, 0, 2, 1, 2, 0);
    for (int i = 0; i < 3; i++) cyc("hit_tick", 1, 0, 2, 1, 2, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk);
    frame_tick = 1'b0;
    rst_n = 1'b1;

    // Floor hit and HIT frame count
    bird_y = 10'd465; pipe_x = 11'd500; pipe_y = 10'd300;
    cyc("start2", 0, 1, 1, 0, 0, 1);
    cyc("floor", 1, 0, 2, 1, 0, 0);
    for (int i = 1; i <= 30; i++) begin
      cyc("hit_gap", 0, 0, 2, 1, 0, 0);
      cyc("hit_cnt", 1, 0, (i == 30) ? 3 : 2, 1, 0, (i == 30) ? 1 : 0);
    end

    // OVER exits only after start is pressed then released
    cyc("over_press", 1, 1, 3, 1, 0, 1);
    cyc("over_held",  1, 1, 3, 1, 0, 1);
    cyc("over_rel",   1, 0, 0, 0, 0, 1);
    cyc("idle_stay",  1, 0, 0, 0, 0, 1);

    // Score saturation
    bird_y = 10'd200;
    cyc("start3", 0, 1, 1, 0, 0, 1);
    for (int n = 1; n <= 1000; n++) begin
      pipe_x = 11'd200;
      cyc("sat_arm",  1, 0, -1, -1, -1, -1);
      pipe_x = 11'd30;
      cyc("sat_pass", 1, 0, -1, -1, (n > 999) ? 999 : n, -1);
    end
    pipe_x = 11'd90; pipe_y = 10'd210;
    cyc("sat_hit", 1, 0, 2, 1, 999, 0);
    for (int i = 1; i <= 30; i++) cyc("sat_hold", 1, 0, (i == 30) ? 3 : 2, 1, 999, -1);
    check_val("high_score", int'(high_score), exp_hs);
    cyc("sat_press", 1, 1, 3, 1, 999, 1);
    cyc("sat_rel",   1, 0, 0, 0, 999, 1);
    check_val("high_keep", int'(high_score), exp_hs);
    cyc("restart",   0, 1, 1, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
